// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
package burst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BEATS            = 4;
    localparam int BEAT_BYTES       = 8;
    localparam int LINE_OFFSET_BITS = 5;

    typedef logic [1:0] beat_t;

endpackage

// File: rtl/burst_mem_if.sv
// Burst physical-memory port: the CPU side is the master, the responder is the slave.
interface burst_mem_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/burst_mem_array.sv
// 64-bit word storage: one synchronous write port, one registered read port.
module burst_mem_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] mem_q [2**AW];
    logic [63:0] rdata_q;
    logic [63:0] rdata_d;

    // Storage is deliberately left without reset so preloaded contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Far-end responder for the burst memory port: 4x64-bit beats per line after a fixed latency.
//   state | meaning
//   IDLE  | accept one request or a backdoor write
//   WAIT  | latency down-count before the first beat
//   BURST | mem_resp high, one beat per cycle
//   DONE  | one dead cycle so the initiator can drop its request
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    burst_mem_if.slave  mem,
    input  logic        bd_we,
    input  logic [31:0] bd_addr,
    input  logic [63:0] bd_wdata,
    output logic        protocol_err
);

    localparam int LINE_BITS = $clog2(DEPTH_LINES);
    localparam int WORD_BITS = LINE_BITS + $clog2(BEATS);

    state_t      state_q, state_d;
    beat_t       beat_q, beat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d;
    logic        mm_seen_q, mm_seen_d;
    logic        err_q, err_d;

    logic                 arr_we;
    logic [WORD_BITS-1:0] arr_waddr;
    logic [63:0]          arr_wdata;
    logic                 arr_re;
    logic [WORD_BITS-1:0] arr_raddr;
    logic [63:0]          arr_rdata;

    logic [LINE_BITS-1:0] line_idx;
    logic                 req_any;
    logic                 mismatch;
    logic                 unused_bd_bits;

    assign line_idx       = addr_q[LINE_OFFSET_BITS +: LINE_BITS];
    assign req_any        = mem.mem_read | mem.mem_write;
    // addr_q holds the raw request address, so a held misaligned address is not a mismatch.
    assign mismatch       = (mem.mem_read == is_write_q) || (mem.mem_write != is_write_q) ||
                            (mem.mem_addr != addr_q);
    assign unused_bd_bits = ^bd_addr;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        mm_seen_d  = mm_seen_q;
        err_d      = 1'b0;
        arr_we     = 1'b0;
        arr_waddr  = bd_addr[3 +: WORD_BITS];
        arr_wdata  = bd_wdata;
        arr_re     = 1'b0;
        arr_raddr  = {line_idx, beat_t'(0)};

        case (state_q)
            IDLE: begin
                if (mem.mem_read && mem.mem_write) begin
                    err_d = 1'b1;
                end else if (req_any) begin
                    is_write_d = mem.mem_write;
                    addr_d     = mem.mem_addr;
                    beat_d     = '0;
                    cnt_d      = 8'(LATENCY - 1);
                    mm_seen_d  = 1'b0;
                    state_d    = WAIT;
                    if (mem.mem_addr[LINE_OFFSET_BITS-1:0] != '0) begin
                        err_d = 1'b1;
                    end
                end
                if (bd_we) begin
                    if (!req_any) begin
                        arr_we = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mismatch && !mm_seen_q) begin
                    err_d     = 1'b1;
                    mm_seen_d = 1'b1;
                end
                if (cnt_q == 8'd0) begin
                    state_d   = BURST;
                    beat_d    = '0;
                    arr_re    = !is_write_q;
                    arr_raddr = {line_idx, beat_t'(0)};
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            BURST: begin
                if (mismatch && !mm_seen_q) begin
                    err_d     = 1'b1;
                    mm_seen_d = 1'b1;
                end
                if (is_write_q) begin
                    arr_we    = 1'b1;
                    arr_waddr = {line_idx, beat_q};
                    arr_wdata = mem.mem_wdata;
                end
                if (beat_q == beat_t'(BEATS - 1)) begin
                    state_d = DONE;
                end else begin
                    beat_d    = beat_q + beat_t'(1);
                    arr_re    = !is_write_q;
                    arr_raddr = {line_idx, beat_t'(beat_q + beat_t'(1))};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bd_we && (state_q != IDLE)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            mm_seen_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            mm_seen_q  <= mm_seen_d;
            err_q      <= err_d;
        end
    end

    burst_mem_array #(
        .AW(WORD_BITS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

    assign mem.mem_resp  = (state_q == BURST);
    assign mem.mem_rdata = arr_rdata;
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Randomized and directed bench for burst_mem_responder against a word-array model.
module tb_burst_mem_responder;

    localparam int DEPTH = 256;
    localparam int WORDS = DEPTH * 4;

    logic clk = 1'b0;
    logic rst4, rst1;
    logic bd_we4, bd_we1;
    logic [31:0] bd_addr4, bd_addr1;
    logic [63:0] bd_wdata4, bd_wdata1;
    logic p_err4, p_err1;

    burst_mem_if if4 ();
    burst_mem_if if1 ();

    burst_mem_responder #(.DEPTH_LINES(DEPTH), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst4), .mem(if4),
        .bd_we(bd_we4), .bd_addr(bd_addr4), .bd_wdata(bd_wdata4),
        .protocol_err(p_err4)
    );

    burst_mem_responder #(.DEPTH_LINES(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .mem(if1),
        .bd_we(bd_we1), .bd_addr(bd_addr1), .bd_wdata(bd_wdata1),
        .protocol_err(p_err1)
    );

    always #5 clk = ~clk;

    logic [63:0] model [2][WORDS];
    int errcnt [2];
    int passed = 0;
    int total  = 0;

    always @(negedge clk) begin
        if (p_err4 === 1'b1) errcnt[0]++;
        if (p_err1 === 1'b1) errcnt[1]++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int widx(input logic [31:0] a, input int k);
        return int'((a / 32) % DEPTH) * 4 + k;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic get_resp(input int w);
        return (w == 1) ? if1.mem_resp : if4.mem_resp;
    endfunction

    function automatic logic [63:0] get_rdata(input int w);
        return (w == 1) ? if1.mem_rdata : if4.mem_rdata;
    endfunction

    task automatic set_req(input int w, input logic rd, input logic wr, input logic [31:0] a);
        if (w == 1) begin
            if1.mem_read = rd; if1.mem_write = wr; if1.mem_addr = a;
        end else begin
            if4.mem_read = rd; if4.mem_write = wr; if4.mem_addr = a;
        end
    endtask

    task automatic set_wdata(input int w, input logic [63:0] d);
        if (w == 1) if1.mem_wdata = d;
        else        if4.mem_wdata = d;
    endtask

    task automatic bd_write(input int w, input logic [31:0] a, input logic [63:0] d);
        @(negedge clk);
        if (w == 1) begin bd_we1 = 1'b1; bd_addr1 = a; bd_wdata1 = d; end
        else        begin bd_we4 = 1'b1; bd_addr4 = a; bd_wdata4 = d; end
        model[w][(a / 8) % WORDS] = d;
        @(posedge clk);
        #1;
        bd_we1 = 1'b0;
        bd_we4 = 1'b0;
    endtask

    task automatic do_burst(input int w, input bit wr, input logic [31:0] addr,
                            input logic [255:0] wd, input int exp_err, input bit glitch);
        int lat;
        int n;
        int e0;
        lat = (w == 1) ? 1 : 4;
        e0  = errcnt[w];
        @(negedge clk);
        set_req(w, !wr, wr, addr);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (glitch && n == 1) set_req(w, !wr, wr, addr ^ 32'h100);
        end while (!get_resp(w) && n < 300);
        chk("first_resp_latency", 64'(n), 64'(lat + 1));
        for (int k = 0; k < 4; k++) begin
            chk("beat_resp", 64'(get_resp(w)), 64'd1);
            if (wr) begin
                set_wdata(w, wd[k*64 +: 64]);
                model[w][widx(addr, k)] = wd[k*64 +: 64];
            end else begin
                chk("beat_rdata", get_rdata(w), model[w][widx(addr, k)]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("done_resp_low", 64'(get_resp(w)), 64'd0);
        if (!wr) chk("rdata_hold", get_rdata(w), model[w][widx(addr, 3)]);
        set_req(w, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("protocol_err_count", 64'(errcnt[w] - e0), 64'(exp_err));
    endtask

    initial begin
        int e0;
        int n;
        int got;
        int cyc [8];
        bit saw;
        bit switched;
        logic [31:0] a;
        logic [255:0] wd;

        rst4 = 1'b1; rst1 = 1'b1;
        bd_we4 = 1'b0; bd_addr4 = '0; bd_wdata4 = '0;
        bd_we1 = 1'b0; bd_addr1 = '0; bd_wdata1 = '0;
        set_req(0, 1'b0, 1'b0, 32'h0); set_wdata(0, 64'h0);
        set_req(1, 1'b0, 1'b0, 32'h0); set_wdata(1, 64'h0);
        errcnt[0] = 0; errcnt[1] = 0;
        repeat (3) @(negedge clk);
        chk("reset_resp", 64'(if4.mem_resp), 64'd0);
        chk("reset_rdata", if4.mem_rdata, 64'd0);
        chk("reset_err", 64'(p_err4), 64'd0);
        rst4 = 1'b0; rst1 = 1'b0;

        for (int i = 0; i < WORDS; i++) bd_write(0, 32'(i * 8), rand64());
        for (int k = 0; k < 4; k++) bd_write(0, 32'h40 + 32'(k * 8), 64'hA0A0_0000_0000_0000 + 64'(k));

        do_burst(0, 1'b0, 32'h0000_0040, '0, 0, 1'b0);
        do_burst(0, 1'b1, 32'h0000_0080,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 1'b0);
        do_burst(0, 1'b0, 32'h0000_0080, '0, 0, 1'b0);
        do_burst(0, 1'b0, 32'h0000_2000, '0, 0, 1'b0);

        e0 = errcnt[0];
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h40);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if4.mem_resp) saw = 1'b1;
        end
        #1;
        chk("both_high_no_resp", 64'(saw), 64'd0);
        chk("both_high_err", 64'(errcnt[0] - e0), 64'd1);

        do_burst(0, 1'b0, 32'h0000_0044, '0, 1, 1'b0);
        do_burst(0, 1'b0, 32'h0000_0100, '0, 1, 1'b1);

        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 32'h0000_00C0);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!if4.mem_resp && n < 300);
        chk("rst_burst_latency", 64'(n), 64'd5);
        for (int k = 0; k < 2; k++) begin
            set_wdata(0, 64'hBEEF_0000_0000_0000 + 64'(k));
            model[0][widx(32'hC0, k)] = 64'hBEEF_0000_0000_0000 + 64'(k);
            @(posedge clk);
            if (k == 0) @(negedge clk);
        end
        #1;
        rst4 = 1'b1;
        #1;
        chk("rst_resp_low", 64'(if4.mem_resp), 64'd0);
        chk("rst_rdata_zero", if4.mem_rdata, 64'd0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0);
        rst4 = 1'b0;
        do_burst(0, 1'b0, 32'h0000_00C0, '0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            a  = $urandom() & 32'hFFFF_FFE0;
            wd = {rand64(), rand64(), rand64(), rand64()};
            do_burst(0, 1'($urandom_range(0, 1)), a, wd, 0, 1'b0);
        end

        for (int k = 0; k < 4; k++) begin
            bd_write(1, 32'h20 + 32'(k * 8), rand64());
            bd_write(1, 32'h60 + 32'(k * 8), rand64());
        end
        e0 = errcnt[1];
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 32'h20);
        got = 0;
        switched = 1'b0;
        for (int c = 1; c <= 40 && got < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if1.mem_resp) begin
                chk("b2b_rdata", if1.mem_rdata,
                    model[1][widx((got < 4) ? 32'h20 : 32'h60, got % 4)]);
                cyc[got] = c;
                got++;
            end else if (got == 4 && !switched) begin
                set_req(1, 1'b1, 1'b0, 32'h60);
                switched = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("b2b_beat_count", 64'(got), 64'd8);
        if (got == 8) begin
            chk("lat1_first_resp", 64'(cyc[0]), 64'd2);
            chk("b2b_contiguous", 64'(cyc[3] - cyc[0]), 64'd3);
            chk("b2b_gap", 64'(cyc[4] - cyc[3]), 64'd4);
        end
        chk("b2b_err", 64'(errcnt[1] - e0), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
